// File: rtl/shift_issue_stage.sv
// -----------------------------------------------------------------------------
// shift_issue_stage
//
// Issue/retire stage sitting in front of the ALU shifters (sll32 / sra32).
// Shift micro-ops from decode are buffered in a 2-entry FIFO; the head entry
// drives the shifter inputs combinationally, and on issue the selected shifter
// result is captured with its destination tag in an output register that is
// handed to writeback over a valid/ready handshake. One op per cycle sustained.
//
// Build option:
//   SHIFT_STAGE_SRA_EN  defined   : OP_SLL and OP_SRA are both legal.
//                       undefined : only OP_SLL is legal; OP_SRA flags
//                                   err_opcode, sra_result is ignored.
//
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   flush                   synchronous squash of all buffered/held ops
//   in_valid / in_ready     decode handshake (in_ready = FIFO not full)
//   in_opcode, in_a,
//   in_shamt, in_tag        op payload from decode
//   sh_a, sh_amt            head operand / amount to the shifters
//   sll_result, sra_result  combinational shifter outputs
//   out_valid / out_ready   writeback handshake
//   out_result, out_tag     registered result and destination tag
//   err_opcode              sticky flag: a non-shift opcode was accepted
// -----------------------------------------------------------------------------
module shift_issue_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SHAMT_W = 5,
   parameter int unsigned TAG_W   = 5
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         in_opcode,
   input  logic [DATA_W-1:0]  in_a,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [TAG_W-1:0]   in_tag,
   output logic [DATA_W-1:0]  sh_a,
   output logic [SHAMT_W-1:0] sh_amt,
   input  logic [DATA_W-1:0]  sll_result,
   input  logic [DATA_W-1:0]  sra_result,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_result,
   output logic [TAG_W-1:0]   out_tag,
   output logic               err_opcode
);

   localparam logic [4:0]  OP_SLL = 5'b00100;
   localparam logic [4:0]  OP_SRA = 5'b00101;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned CNT_W  = 2;

   // FIFO entry payload; the op bit only exists when SRA is built in.
   typedef struct packed {
`ifdef SHIFT_STAGE_SRA_EN
      logic               op_sra;
`endif
      logic [DATA_W-1:0]  a;
      logic [SHAMT_W-1:0] shamt;
      logic [TAG_W-1:0]   tag;
   } entry_t;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_d;

   entry_t             fifo_q [DEPTH];
   logic               wr_ptr_q;
   logic               rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               ready_q;

   entry_t             in_entry_c;
   entry_t             head_c;
   logic               legal_c;
   logic               accept_c;
   logic               push_c;
   logic               issue_c;
   logic               nonempty_c;
   logic [DATA_W-1:0]  result_sel_c;

`ifndef SHIFT_STAGE_SRA_EN
   // sra_result has no consumer in the SLL-only build.
   logic               sra_unused;
   assign sra_unused = ^sra_result;
`endif

   // Opcode legality decode.
   always_comb begin
      legal_c = (in_opcode == OP_SLL);
`ifdef SHIFT_STAGE_SRA_EN
      if (in_opcode == OP_SRA) begin
         legal_c = 1'b1;
      end
`endif
   end

   // Ready depends on registered state only; ready_q holds it low until the
   // first edge after reset release.
   assign in_ready   = ready_q && (count_q < CNT_W'(DEPTH));
   assign accept_c   = in_valid && in_ready;
   assign nonempty_c = (count_q != '0);
   assign head_c     = fifo_q[rd_ptr_q];

   // Pack the incoming op into a FIFO entry.
   always_comb begin
      in_entry_c       = '0;
`ifdef SHIFT_STAGE_SRA_EN
      in_entry_c.op_sra = (in_opcode == OP_SRA);
`endif
      in_entry_c.a     = in_a;
      in_entry_c.shamt = in_shamt;
      in_entry_c.tag   = in_tag;
   end

   // Shifter drive straight from FIFO storage; zero when nothing is buffered.
   assign sh_a   = nonempty_c ? head_c.a     : '0;
   assign sh_amt = nonempty_c ? head_c.shamt : '0;

   // Result select between the two shifters.
   always_comb begin
      result_sel_c = sll_result;
`ifdef SHIFT_STAGE_SRA_EN
      if (head_c.op_sra) begin
         result_sel_c = sra_result;
      end
`endif
   end

   // Output-register FSM: state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Output-register FSM: next state. Flush wins over everything.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (issue_c) begin
                  state_d = S_FULL;
               end
            end
            S_FULL: begin
               if (issue_c) begin
                  state_d = S_FULL;
               end else if (out_ready) begin
                  state_d = S_EMPTY;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
   end

   // Output-register FSM: control outputs. Issue needs a head entry and a
   // free (or freeing) output register; flush suppresses both push and issue.
   always_comb begin
      issue_c = 1'b0;
      push_c  = 1'b0;
      if (!flush) begin
         issue_c = nonempty_c && ((state_q == S_EMPTY) || out_ready);
         push_c  = accept_c && legal_c;
      end
   end

   assign out_valid = (state_q == S_FULL);

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
         end else begin
            if (push_c) begin
               fifo_q[wr_ptr_q] <= in_entry_c;
               wr_ptr_q         <= ~wr_ptr_q;
            end
            if (issue_c) begin
               rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(issue_c);
         end
      end
   end

   // Output data register; holds while the FSM is FULL and stalled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_result <= '0;
         out_tag    <= '0;
      end else if (issue_c) begin
         out_result <= result_sel_c;
         out_tag    <= head_c.tag;
      end
   end

   // Sticky illegal-opcode flag; only reset clears it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_opcode <= 1'b0;
      end else if (accept_c && !legal_c) begin
         err_opcode <= 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_stage
//
// Directed bench for shift_issue_stage. The two shifters are modelled as
// plain combinational shifts of sh_a by sh_amt; all expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_shift_issue_stage;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned TAG_W   = 5;
   localparam logic [4:0]  OP_SLL  = 5'b00100;
   localparam logic [4:0]  OP_SRA  = 5'b00101;
`ifdef SHIFT_STAGE_SRA_EN
   localparam bit SRA_EN = 1'b1;
`else
   localparam bit SRA_EN = 1'b0;
`endif

   logic               clk;
   logic               rst_n;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [4:0]         in_opcode;
   logic [DATA_W-1:0]  in_a;
   logic [SHAMT_W-1:0] in_shamt;
   logic [TAG_W-1:0]   in_tag;
   logic [DATA_W-1:0]  sh_a;
   logic [SHAMT_W-1:0] sh_amt;
   logic [DATA_W-1:0]  sll_result;
   logic [DATA_W-1:0]  sra_result;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_result;
   logic [TAG_W-1:0]   out_tag;
   logic               err_opcode;

   int n_vec;
   int n_bad;

   shift_issue_stage #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W),
      .TAG_W   (TAG_W)
   ) dut (
      .clock      (clk),
      .reset_n    (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_a       (in_a),
      .in_shamt   (in_shamt),
      .in_tag     (in_tag),
      .sh_a       (sh_a),
      .sh_amt     (sh_amt),
      .sll_result (sll_result),
      .sra_result (sra_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .err_opcode (err_opcode)
   );

   // External shifter models.
   assign sll_result = sh_a << sh_amt;
   assign sra_result = DATA_W'($signed(sh_a) >>> sh_amt);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [DATA_W-1:0] a,
                        input logic [SHAMT_W-1:0] sh, input logic [TAG_W-1:0] tg);
      in_valid  = 1'b1;
      in_opcode = op;
      in_a      = a;
      in_shamt  = sh;
      in_tag    = tg;
   endtask

   task automatic idle;
      in_valid  = 1'b0;
      in_opcode = '0;
      in_a      = '0;
      in_shamt  = '0;
      in_tag    = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      idle();

      // Reset state.
      tick(); tick(); tick();
      check("rst_out_valid",  out_valid,  0);
      check("rst_out_result", out_result, 0);
      check("rst_out_tag",    out_tag,    0);
      check("rst_err",        err_opcode, 0);
      check("rst_sh_a",       sh_a,       0);
      check("rst_sh_amt",     sh_amt,     0);
      rst_n = 1'b1;
      tick();
      check("rdy_after_rst", in_ready, 1);

      // SLL 1 << 31, two-cycle latency, valid for one cycle.
      drive(OP_SLL, 32'h0000_0001, 5'd31, 5'd3);
      tick();
      idle();
      check("t1_sh_a",    sh_a,      32'h0000_0001);
      check("t1_sh_amt",  sh_amt,    31);
      check("t1_valid_n", out_valid, 0);
      tick();
      check("t1_valid",   out_valid,  1);
      check("t1_result",  out_result, 32'h8000_0000);
      check("t1_tag",     out_tag,    3);
      tick();
      check("t1_one_cyc", out_valid,  0);
      check("t1_err",     err_opcode, 0);

      // SRA: legal only when the SRA build option is on.
      drive(OP_SRA, 32'h8000_0000, 5'd4, 5'd7);
      tick();
      idle();
      check("sra_sh_a", sh_a,       SRA_EN ? 32'h8000_0000 : 32'h0);
      check("sra_err",  err_opcode, SRA_EN ? 1'b0 : 1'b1);
      tick();
      check("sra_valid", out_valid, SRA_EN ? 1'b1 : 1'b0);
      if (SRA_EN) begin
         check("sra_result", out_result, 32'hF800_0000);
         check("sra_tag",    out_tag,    7);
      end
      tick();
      check("sra_drain", out_valid, 0);

      // Illegal opcode: handshake completes, nothing enqueued, sticky error.
      drive(5'b00000, 32'h0000_1234, 5'd1, 5'd1);
      check("ill_ready", in_ready, 1);
      tick();
      idle();
      check("ill_err",   err_opcode, 1);
      check("ill_sh_a",  sh_a,       0);
      check("ill_rdy",   in_ready,   1);
      tick();
      check("ill_novalid", out_valid,  0);
      check("ill_sticky",  err_opcode, 1);

      // Back-to-back retire, including shamt = 0.
      drive(OP_SLL, 32'hDEAD_BEEF, 5'd0, 5'd10);
      tick();
      drive(OP_SLL, 32'h0000_00F0, 5'd8, 5'd11);
      tick();
      idle();
      check("b2b_valid0",  out_valid,  1);
      check("b2b_result0", out_result, 32'hDEAD_BEEF);
      check("b2b_tag0",    out_tag,    10);
      tick();
      check("b2b_valid1",  out_valid,  1);
      check("b2b_result1", out_result, 32'h0000_F000);
      check("b2b_tag1",    out_tag,    11);
      tick();
      check("b2b_drain", out_valid, 0);

      // Backpressure: capacity three, held output stable, in-order release.
      out_ready = 1'b0;
      drive(OP_SLL, 32'h1, 5'd1, 5'd1);
      tick();
      check("bp_rdy1", in_ready, 1);
      drive(OP_SLL, 32'h1, 5'd2, 5'd2);
      tick();
      check("bp_valid", out_valid,  1);
      check("bp_res2",  out_result, 32'h2);
      drive(OP_SLL, 32'h1, 5'd3, 5'd3);
      tick();
      check("bp_full", in_ready, 0);
      drive(OP_SLL, 32'h1, 5'd4, 5'd4);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_res", out_result, 32'h2);
         check("bp_hold_tag", out_tag,    1);
         check("bp_hold_vld", out_valid,  1);
         check("bp_hold_rdy", in_ready,   0);
      end
      out_ready = 1'b1;
      tick();
      check("bp_res4",  out_result, 32'h4);
      check("bp_tag2",  out_tag,    2);
      check("bp_rdy2",  in_ready,   1);
      tick();
      idle();
      check("bp_res8",  out_result, 32'h8);
      check("bp_tag3",  out_tag,    3);
      tick();
      check("bp_res10", out_result, 32'h10);
      check("bp_tag4",  out_tag,    4);
      check("bp_vld4",  out_valid,  1);
      tick();
      check("bp_drain", out_valid, 0);

      // Flush with two buffered + one held and an op offered.
      out_ready = 1'b0;
      drive(OP_SLL, 32'h1, 5'd1, 5'd1);
      tick();
      drive(OP_SLL, 32'h1, 5'd2, 5'd2);
      tick();
      drive(OP_SLL, 32'h1, 5'd3, 5'd3);
      tick();
      check("fl_full",  in_ready,  0);
      check("fl_held",  out_valid, 1);
      drive(OP_SLL, 32'h5, 5'd1, 5'd4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle();
      check("fl_valid", out_valid, 0);
      check("fl_rdy",   in_ready,  1);
      check("fl_sh_a",  sh_a,      0);
      check("fl_sh_amt", sh_amt,   0);
      out_ready = 1'b1;
      tick(); tick();
      check("fl_lost", out_valid, 0);

      // Flush while the stage could accept: offered op is still lost.
      drive(OP_SLL, 32'h5, 5'd1, 5'd4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle();
      check("fl2_sh_a", sh_a, 0);
      tick();
      check("fl2_valid", out_valid, 0);
      check("fl2_err",   err_opcode, 1);

      // Async reset mid-stream.
      out_ready = 1'b0;
      drive(OP_SLL, 32'h11, 5'd4, 5'd5);
      tick();
      drive(OP_SLL, 32'h22, 5'd0, 5'd6);
      tick();
      idle();
      check("ar_valid", out_valid,  1);
      check("ar_res",   out_result, 32'h110);
      check("ar_sh_a",  sh_a,       32'h22);
      #3;
      rst_n = 1'b0;
      #1;
      check("ar_valid0", out_valid,  0);
      check("ar_res0",   out_result, 0);
      check("ar_tag0",   out_tag,    0);
      check("ar_sh_a0",  sh_a,       0);
      check("ar_err0",   err_opcode, 0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      check("ar_rdy", in_ready, 1);
      drive(OP_SLL, 32'h3, 5'd2, 5'd9);
      tick();
      idle();
      check("ar_lat_n", out_valid, 0);
      tick();
      check("ar_lat",  out_valid,  1);
      check("ar_res1", out_result, 32'hC);
      check("ar_tag1", out_tag,    9);
      tick();
      check("ar_drain", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
Issue/retire stage directly upstream of the ALU shifters: sll32, and an sra32 that has the same port shape. It buffers shift micro-ops from decode in a 2-entry FIFO and drives the head entry's operand and shift amount into the shifters. It captures the selected shifter result together with the destination tag in an output register, and hands it to writeback over a valid/ready handshake. Sustained throughput is one op per cycle.

Parameters:
DATA_W, 32, operand/result width
SHAMT_W, 5, shift-amount width (log2 DATA_W)
TAG_W, 5, destination register tag width
OP_SLL, 5'b00100, ALU opcode for logical left shift
OP_SRA, 5'b00101, ALU opcode for arithmetic right shift

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash of all buffered/held ops
in_valid  in  1  decode presents an op
in_ready  out  1  stage can accept (FIFO not full)
in_opcode  in  5  ALU opcode
in_a  in  DATA_W  operand to shift
in_shamt  in  SHAMT_W  shift amount
in_tag  in  TAG_W  destination register
sh_a  out  DATA_W  operand to sll32/sra32 input a
sh_amt  out  SHAMT_W  to sll32/sra32 select
sll_result  in  DATA_W  from sll32 out (combinational)
sra_result  in  DATA_W  from sra32 out (combinational)
out_valid  out  1  result held
out_ready  in  1  writeback accepts
out_result  out  DATA_W  registered shift result
out_tag  out  TAG_W  registered destination tag
err_opcode  out  1  sticky: non-shift opcode offered

Behaviour:
- Reset (reset_n low, async): FIFO empty; output register EMPTY; out_valid=0; out_result=0; out_tag=0; err_opcode=0; sh_a=0; sh_amt=0. in_ready=1 from the first edge after release.
- Accept: in_valid && in_ready at a rising edge.
  - Opcode OP_SLL or OP_SRA: entry {op bit, a, shamt, tag} written at the tail.
  - Any other opcode: entry not written; err_opcode set to 1, cleared only by reset.
- FIFO:
  - 2 entries; wr/rd pointers with wrap; count 0..2.
  - in_ready = (count<2), combinational from registered state only.
  - Push and pop in the same cycle when count==2 is legal only if the pop frees a slot that cycle; in_ready still reads 0 in that cycle. No same-cycle pass-through.
- Output register FSM, two states:
  - EMPTY→FULL on issue.
  - FULL→FULL on issue && out_ready (back-to-back).
  - FULL→EMPTY on out_ready && !issue.
  - FULL holds on !out_ready.
- Issue condition: count>0 && (state==EMPTY || out_ready).
- Shifter drive:
  - sh_a/sh_amt = head entry whenever count>0; else 0.
  - Driven combinationally from FIFO storage.
- On issue, the rising edge:
  - captures out_result = op?sra_result:sll_result, and out_tag = head tag;
  - pops the head.
- Latency: accepted at edge N → out_valid=1 after edge N+1 (2 cycles). Back-to-back ops retire 1/cycle with out_ready=1.
- Total capacity 3 ops (2 FIFO + 1 output). out_ready=0 never drops or overwrites an op; out_result/out_tag stable while out_valid && !out_ready.
- Flush (synchronous, highest priority):
  - Next edge empties the FIFO, sets the output register EMPTY and out_valid=0.
  - A same-cycle input handshake is discarded; err_opcode is unaffected.
- Reset mid-operation discards all ops immediately (async); no output handshake completes in that cycle.
- Shift amount is used as-is (0..31); shamt=0 yields the operand unchanged.

Optional Feature:
- Macro SHIFT_STAGE_SRA_EN.
- Defined: behaviour as above.
- Undefined:
  - OP_SRA is treated as illegal (sets err_opcode, not enqueued).
  - sra_result is ignored and the op storage bit is removed; out_result always comes from sll_result.

Test Plan:
- Reset then accept OP_SLL a=0x0000_0001 shamt=31 tag=3, out_ready=1 → out_valid 2 cycles later, out_result=0x8000_0000, out_tag=3, one cycle only.
- OP_SRA a=0x8000_0000 shamt=4 tag=7 (SRA_EN defined) → out_result=0xF800_0000; with the macro undefined → err_opcode=1, no out_valid.
- out_ready=0; offer 4 SLL ops a=1, shamt=1,2,3,4 → in_ready low after 3 accepted. Output holds 0x2 stable. Releasing out_ready retires 0x2, 0x4, 0x8, then the 4th op 0x10 in order, one per cycle.
- Opcode 5'b00000 with in_valid → handshake completes, err_opcode=1 permanently, no entry, count unchanged.
- Two ops buffered plus one held; assert flush with in_valid high → next cycle out_valid=0, count=0, the offered op is lost, in_ready=1.
- Drop reset_n mid-stream while out_valid=1 → out_valid, out_result, sh_a fall to 0 asynchronously (before the next edge); first op after release retires with 2-cycle latency.
